bitmanip_issue_sequencer: RTL and testbench
===========================================

// Module: bitmanip_issue_sequencer
// PURPOSE
//  Execute-stage controller that sits between decode/issue and the bit manipulation unit (BMU) datapath.
//  Accepts one bit-op at a time over a valid/ready handshake. Registers its operands and sequences the
//  BMU's registered 1-cycle datapath (enable pulse, then capture). Runs carry-less multiply ops on an
//  iterative sub-unit. Returns the result to writeback over a valid/ready handshake, with flush support.
// PARAMETERS
//  XLEN      32  operand/result width
//  OP_W      5   bit-op code width (shared with BMU)
//  TAG_W     5   destination register tag width
//  CLMUL_BPC 1   product bits retired per CLMUL_RUN cycle; must divide XLEN
// PORTS
//  clk_i           in   1      clock
//  rst_ni          in   1      asynchronous reset, active-low
//  flush_i         in   1      pipeline flush; kills the in-flight op
//  req_valid_i     in   1      issue request valid
//  req_ready_o     out  1      sequencer can accept
//  req_op_i        in   OP_W   bit-op code
//  req_rs1_i       in   XLEN   operand 1
//  req_rs2_i       in   XLEN   operand 2
//  req_rd_i        in   TAG_W  destination tag
//  bmu_enable_o    out  1      BMU enable (1-cycle pulse)
//  bmu_op_o        out  OP_W   BMU op code (registered)
//  bmu_operand1_o  out  XLEN   BMU operand 1 (registered)
//  bmu_operand2_o  out  XLEN   BMU operand 2 (registered)
//  bmu_result_i    in   XLEN   BMU registered result
//  resp_valid_o    out  1      result valid to writeback
//  resp_ready_i    in   1      writeback accepts
//  resp_result_o   out  XLEN   result
//  resp_rd_o       out  TAG_W  destination tag of the result
//  resp_illegal_o  out  1      op code unsupported; result is 0
//  busy_o          out  1      state != IDLE
// BEHAVIOUR
//  - Reset (rst_ni low, async): state IDLE; all registers and outputs 0 except req_ready_o. req_ready_o = 1
//    once rst_ni is high. Reset mid-operation drops the op; no response is produced.
//  - FSM states: IDLE, ISSUE, CAPTURE, CLMUL_RUN, RESP.
//  - req_ready_o = (state==IDLE) & ~flush_i. Accept on req_valid_i & req_ready_o.
//    Accept latches op, rs1, rs2 and rd. At most one op is in flight; there is no same-cycle re-accept.
//  - Plain op (code < BMU_OP_CLMUL): IDLE -> ISSUE (bmu_enable_o=1 for exactly one cycle) -> CAPTURE
//    (latch bmu_result_i) -> RESP. resp_valid_o rises 3 cycles after the accept edge.
//  - CLMUL/CLMULH/CLMULR: IDLE -> CLMUL_RUN for XLEN/CLMUL_BPC cycles (down-counter; sub-unit start on
//    entry) -> RESP. CLMUL = product[XLEN-1:0], CLMULH = product[2XLEN-1:XLEN],
//    CLMULR = product[2XLEN-2:XLEN-1]. The product is 2*XLEN wide and carry-less.
//  - Op code > BMU_OP_LAST: IDLE -> RESP next cycle with resp_illegal_o=1, resp_result_o=0.
//  - RESP: resp_valid_o=1. resp_* outputs stay stable while resp_ready_i is low. On handshake -> IDLE.
//  - flush_i (any state): next state IDLE, resp_valid_o low next cycle, counter cleared, sub-unit aborted.
//    Flush together with a RESP handshake: the transfer counts as done, then IDLE.
//    Flush has priority over accept.
//  - bmu_op_o and operands hold their last registered values outside ISSUE; bmu_enable_o is 0 outside ISSUE.
// CONFIGURATION
//  BMU_CLMUL_EN defined: CLMUL ops run through the iterative sub-unit as above.
//  BMU_CLMUL_EN undefined: sub-unit not instantiated; CLMUL codes take the illegal path
//    (resp_illegal_o=1, result 0, 1-cycle latency).
// STRUCTURE
//  - Shared package bmu_pkg: XLEN, OP_W, op code constants (BMU_OP_CLMUL=5'h10, BMU_OP_CLMULH=5'h11,
//    BMU_OP_CLMULR=5'h12, BMU_OP_LAST=5'h12), FSM state encoding. Plain BMU ops are the codes below 5'h10.
//  - One sub-module, bmu_clmul_iter: start/abort in, done out; shift-and-XOR of CLMUL_BPC bits/cycle;
//    2*XLEN product register.
// TESTING (bench BMU stub: result <= op1 ^ op2 on enable)
//  1 Plain op 5'h01, rs1=0x1234_5678, rs2=0xFFFF_0000, rd=7 -> bmu_enable_o one pulse; resp_valid_o
//    3 cycles after accept; result 0xEDCB_5678, rd 7, illegal 0.
//  2 CLMUL rs1=rs2=0x3 -> result 0x5 after 33 cycles. CLMULH rs1=rs2=0x8000_0000 -> 0x4000_0000.
//    CLMULR same operands -> 0x8000_0000.
//  3 Backpressure: resp_ready_i low 5 cycles -> resp_* stable, req_ready_o 0; ready high -> IDLE next
//    cycle, req_ready_o 1.
//  4 flush_i in CLMUL_RUN cycle 10 -> no response, req_ready_o 1 next cycle; following plain op is correct.
//    flush_i together with req_valid_i -> not accepted.
//  5 Op 5'h1F -> resp next cycle, illegal 1, result 0. Without BMU_CLMUL_EN, CLMUL 0x3*0x3 -> illegal 1,
//    result 0.
//  6 rst_ni low during CAPTURE -> all outputs 0 immediately; after release, IDLE, no stale response.

Source files
------------

// File: rtl/bmu_pkg.sv
// Shared BMU definitions: widths, bit-op codes and the issue sequencer state encoding.
package bmu_pkg;

   localparam int BMU_XLEN = 32;
   localparam int BMU_OP_W = 5;

   localparam logic [4:0] BMU_OP_CLMUL  = 5'h10;
   localparam logic [4:0] BMU_OP_CLMULH = 5'h11;
   localparam logic [4:0] BMU_OP_CLMULR = 5'h12;
   localparam logic [4:0] BMU_OP_LAST   = 5'h12;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ISSUE     = 3'd1;
   localparam logic [2:0] ST_CAPTURE   = 3'd2;
   localparam logic [2:0] ST_CLMUL_RUN = 3'd3;
   localparam logic [2:0] ST_RESP      = 3'd4;

   function automatic logic is_clmul_op(input logic [4:0] op);
      return (op == BMU_OP_CLMUL) || (op == BMU_OP_CLMULH) || (op == BMU_OP_CLMULR);
   endfunction

endpackage

// File: rtl/bmu_clmul_iter.sv
// Iterative carry-less multiplier: BPC multiplier bits are folded into a 2*XLEN product each cycle.
// done is high during the last iteration; product_nxt then already holds the final product.
module bmu_clmul_iter #(
   parameter int XLEN = 32,
   parameter int BPC  = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start,
   input  logic              abort,
   input  logic [XLEN-1:0]   op1,
   input  logic [XLEN-1:0]   op2,
   output logic              done,
   output logic [2*XLEN-1:0] product_nxt
);

   localparam int STEPS = XLEN / BPC;
   localparam int CNT_W = $clog2(STEPS + 1);

   logic [2*XLEN-1:0] mcand_q;
   logic [2*XLEN-1:0] prod_q;
   logic [XLEN-1:0]   mplier_q;
   logic [CNT_W-1:0]  cnt_q;

   always_comb begin
      product_nxt = prod_q;
      for (int j = 0; j < BPC; j++) begin
         if (mplier_q[j]) product_nxt = product_nxt ^ (mcand_q << j);
      end
   end

   assign done = (cnt_q == CNT_W'(1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else if (abort) begin
         cnt_q    <= '0;
      end else if (start) begin
         mcand_q  <= {{XLEN{1'b0}}, op1};
         mplier_q <= op2;
         prod_q   <= '0;
         cnt_q    <= CNT_W'(STEPS);
      end else if (cnt_q != '0) begin
         prod_q   <= product_nxt;
         mcand_q  <= mcand_q << BPC;
         mplier_q <= mplier_q >> BPC;
         cnt_q    <= cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/bitmanip_issue_sequencer.sv
// Execute-stage controller between issue and the BMU datapath; returns results to writeback.
// Define BMU_CLMUL_EN to run CLMUL/CLMULH/CLMULR on bmu_clmul_iter; otherwise those codes are illegal.
//
// state     | meaning
// IDLE      | waiting for an issue request
// ISSUE     | bmu_enable_o pulse, registered operands presented to the BMU
// CAPTURE   | BMU result valid, latched into the response register
// CLMUL_RUN | carry-less multiply iterating on the sub-unit
// RESP      | response held until writeback accepts
module bitmanip_issue_sequencer #(
   parameter int XLEN      = bmu_pkg::BMU_XLEN,
   parameter int OP_W      = bmu_pkg::BMU_OP_W,
   parameter int TAG_W     = 5,
   parameter int CLMUL_BPC = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [OP_W-1:0]  req_op_i,
   input  logic [XLEN-1:0]  req_rs1_i,
   input  logic [XLEN-1:0]  req_rs2_i,
   input  logic [TAG_W-1:0] req_rd_i,
   output logic             bmu_enable_o,
   output logic [OP_W-1:0]  bmu_op_o,
   output logic [XLEN-1:0]  bmu_operand1_o,
   output logic [XLEN-1:0]  bmu_operand2_o,
   input  logic [XLEN-1:0]  bmu_result_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [XLEN-1:0]  resp_result_o,
   output logic [TAG_W-1:0] resp_rd_o,
   output logic             resp_illegal_o,
   output logic             busy_o
);
   import bmu_pkg::*;

   if ((XLEN % CLMUL_BPC) != 0) begin : g_bpc_check
      $error("CLMUL_BPC must divide XLEN");
   end

   logic [2:0]       state_q, state_d;
   logic [OP_W-1:0]  op_q;
   logic [XLEN-1:0]  opa_q, opb_q, res_q;
   logic [TAG_W-1:0] rd_q;
   logic             illegal_q;
   logic             accept, clmul_op, dec_illegal, clmul_done;
   logic [XLEN-1:0]  clmul_res;

`ifdef BMU_CLMUL_EN
   logic [2*XLEN-1:0] clmul_prod;

   assign clmul_op = is_clmul_op(req_op_i);

   bmu_clmul_iter #(.XLEN(XLEN), .BPC(CLMUL_BPC)) u_clmul (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .start       (accept & clmul_op),
      .abort       (flush_i),
      .op1         (req_rs1_i),
      .op2         (req_rs2_i),
      .done        (clmul_done),
      .product_nxt (clmul_prod)
   );

   always_comb begin
      case (op_q)
         BMU_OP_CLMULH: clmul_res = clmul_prod[2*XLEN-1:XLEN];
         BMU_OP_CLMULR: clmul_res = clmul_prod[2*XLEN-2:XLEN-1];
         default:       clmul_res = clmul_prod[XLEN-1:0];
      endcase
   end
`else
   assign clmul_op   = 1'b0;
   assign clmul_done = 1'b0;
   assign clmul_res  = '0;
`endif

   // Gated by rst_ni so every output reads 0 while reset is held.
   assign req_ready_o = rst_ni & (state_q == ST_IDLE) & ~flush_i;
   assign accept      = req_valid_i & req_ready_o;
   assign dec_illegal = ~(req_op_i < BMU_OP_CLMUL) & ~clmul_op;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (dec_illegal)   state_d = ST_RESP;
               else if (clmul_op) state_d = ST_CLMUL_RUN;
               else               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE:     state_d = ST_CAPTURE;
         ST_CAPTURE:   state_d = ST_RESP;
         ST_CLMUL_RUN: if (clmul_done) state_d = ST_RESP;
         ST_RESP:      if (resp_ready_i) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
      if (flush_i) state_d = ST_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         rd_q      <= '0;
         res_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q      <= req_op_i;
            opa_q     <= req_rs1_i;
            opb_q     <= req_rs2_i;
            rd_q      <= req_rd_i;
            illegal_q <= dec_illegal;
            res_q     <= '0;
         end else if (state_q == ST_CAPTURE) begin
            res_q <= bmu_result_i;
         end else if ((state_q == ST_CLMUL_RUN) && clmul_done) begin
            res_q <= clmul_res;
         end
      end
   end

   assign bmu_enable_o   = (state_q == ST_ISSUE);
   assign bmu_op_o       = op_q;
   assign bmu_operand1_o = opa_q;
   assign bmu_operand2_o = opb_q;
   assign resp_valid_o   = (state_q == ST_RESP);
   assign resp_result_o  = res_q;
   assign resp_rd_o      = rd_q;
   assign resp_illegal_o = illegal_q;
   assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bitmanip_issue_sequencer.sv
// Bench for bitmanip_issue_sequencer: directed table, hand-written flush/reset sequences, random ops vs model.
module tb_bitmanip_issue_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [4:0]  req_op_i = '0;
   logic [31:0] req_rs1_i = '0;
   logic [31:0] req_rs2_i = '0;
   logic [4:0]  req_rd_i = '0;
   logic        bmu_enable_o;
   logic [4:0]  bmu_op_o;
   logic [31:0] bmu_operand1_o;
   logic [31:0] bmu_operand2_o;
   logic [31:0] bmu_result_i;
   logic        resp_valid_o;
   logic        resp_ready_i = 1'b0;
   logic [31:0] resp_result_o;
   logic [4:0]  resp_rd_o;
   logic        resp_illegal_o;
   logic        busy_o;

   int tests = 0;
   int fails = 0;

   always #5 clk_i = ~clk_i;

   bitmanip_issue_sequencer dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .flush_i        (flush_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_op_i       (req_op_i),
      .req_rs1_i      (req_rs1_i),
      .req_rs2_i      (req_rs2_i),
      .req_rd_i       (req_rd_i),
      .bmu_enable_o   (bmu_enable_o),
      .bmu_op_o       (bmu_op_o),
      .bmu_operand1_o (bmu_operand1_o),
      .bmu_operand2_o (bmu_operand2_o),
      .bmu_result_i   (bmu_result_i),
      .resp_valid_o   (resp_valid_o),
      .resp_ready_i   (resp_ready_i),
      .resp_result_o  (resp_result_o),
      .resp_rd_o      (resp_rd_o),
      .resp_illegal_o (resp_illegal_o),
      .busy_o         (busy_o)
   );

   // BMU stub: registered XOR of the presented operands.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)           bmu_result_i <= '0;
      else if (bmu_enable_o) bmu_result_i <= bmu_operand1_o ^ bmu_operand2_o;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] clmul64(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = '0;
      for (int i = 0; i < 32; i++) if (b[i]) p = p ^ ({32'b0, a} << i);
      return p;
   endfunction

   function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ill, output int lat);
      logic [63:0] p;
      p = clmul64(a, b);
      r = '0; ill = 1'b1; lat = 1;
      if (op < 5'h10) begin
         r = a ^ b; ill = 1'b0; lat = 3;
      end
`ifdef BMU_CLMUL_EN
      else if (op == 5'h10) begin r = p[31:0];  ill = 1'b0; lat = 33; end
      else if (op == 5'h11) begin r = p[63:32]; ill = 1'b0; lat = 33; end
      else if (op == 5'h12) begin r = p[62:31]; ill = 1'b0; lat = 33; end
`endif
   endfunction

   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      @(negedge clk_i);
      req_valid_i = 1'b1; req_op_i = op; req_rs1_i = a; req_rs2_i = b; req_rd_i = rd;
      @(negedge clk_i);
      req_valid_i = 1'b0;
   endtask

   task automatic run_op(input string nm, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int hold, input logic [31:0] er, input logic ei,
                         input int elat);
      int n;
      int en_cnt;
      resp_ready_i = 1'b0;
      @(negedge clk_i);
      check({nm, " ready_before"}, req_ready_o, 1);
      req_valid_i = 1'b1; req_op_i = op; req_rs1_i = a; req_rs2_i = b; req_rd_i = rd;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      if (op < 5'h10) begin
         check({nm, " bmu_op"}, bmu_op_o, op);
         check({nm, " bmu_opnd1"}, bmu_operand1_o, a);
         check({nm, " bmu_opnd2"}, bmu_operand2_o, b);
      end
      n = 1; en_cnt = 0;
      while (!resp_valid_o && n < 200) begin
         en_cnt += int'(bmu_enable_o);
         @(negedge clk_i);
         n++;
      end
      check({nm, " latency"}, n, elat);
      check({nm, " enable_pulses"}, en_cnt, (op < 5'h10) ? 1 : 0);
      check({nm, " result"}, resp_result_o, er);
      check({nm, " rd"}, resp_rd_o, rd);
      check({nm, " illegal"}, resp_illegal_o, ei);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk_i);
         check({nm, " hold_valid"}, resp_valid_o, 1);
         check({nm, " hold_result"}, resp_result_o, er);
         check({nm, " hold_ready"}, req_ready_o, 0);
      end
      resp_ready_i = 1'b1;
      @(negedge clk_i);
      resp_ready_i = 1'b0;
      check({nm, " post_valid"}, resp_valid_o, 0);
      check({nm, " post_ready"}, req_ready_o, 1);
      check({nm, " post_busy"}, busy_o, 0);
   endtask

   task automatic expect_quiet(input string nm, input int cycles);
      int seen;
      seen = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk_i);
         seen += int'(resp_valid_o);
      end
      check({nm, " no_stale_resp"}, seen, 0);
   endtask

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      int          hold;
      logic [31:0] res;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [31:0] r;
      logic        ill;
      int          lat;
      logic [4:0]  op;
      logic [31:0] a, b;
`ifdef BMU_CLMUL_EN
      localparam bit CLMUL_ON = 1'b1;
`else
      localparam bit CLMUL_ON = 1'b0;
`endif

      tbl.push_back('{5'h01, 32'h1234_5678, 32'hFFFF_0000, 5'd7,  0, 32'hEDCB_5678, 1'b0, 3});
      tbl.push_back('{5'h0F, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'd31, 5, 32'hFFFF_FFFF, 1'b0, 3});
      tbl.push_back('{5'h00, 32'h0,         32'h0,         5'd0,  0, 32'h0,         1'b0, 3});
      tbl.push_back('{5'h1F, 32'h1234,      32'h5678,      5'd3,  2, 32'h0,         1'b1, 1});
      tbl.push_back('{5'h13, 32'hFFFF_FFFF, 32'h1,         5'd9,  0, 32'h0,         1'b1, 1});
      tbl.push_back('{5'h10, 32'h3, 32'h3, 5'd2, 0,
                      CLMUL_ON ? 32'h5 : 32'h0, !CLMUL_ON, CLMUL_ON ? 33 : 1});
      tbl.push_back('{5'h11, 32'h8000_0000, 32'h8000_0000, 5'd4, 1,
                      CLMUL_ON ? 32'h4000_0000 : 32'h0, !CLMUL_ON, CLMUL_ON ? 33 : 1});
      tbl.push_back('{5'h12, 32'h8000_0000, 32'h8000_0000, 5'd5, 0,
                      CLMUL_ON ? 32'h8000_0000 : 32'h0, !CLMUL_ON, CLMUL_ON ? 33 : 1});
      tbl.push_back('{5'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0,
                      CLMUL_ON ? 32'h5555_5555 : 32'h0, !CLMUL_ON, CLMUL_ON ? 33 : 1});
      tbl.push_back('{5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 3,
                      CLMUL_ON ? 32'h5555_5555 : 32'h0, !CLMUL_ON, CLMUL_ON ? 33 : 1});

      // Reset state
      #1;
      check("rst req_ready", req_ready_o, 0);
      check("rst resp_valid", resp_valid_o, 0);
      check("rst bmu_enable", bmu_enable_o, 0);
      check("rst busy", busy_o, 0);
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check("rst_release req_ready", req_ready_o, 1);

      foreach (tbl[i]) begin
         run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].hold,
                tbl[i].res, tbl[i].ill, tbl[i].lat);
      end

      // Flush while a plain op sits in CAPTURE
      issue(5'h02, 32'h1111_0000, 32'h0000_2222, 5'd10);
      @(negedge clk_i);
      flush_i = 1'b1;
      @(negedge clk_i);
      check("flush_capture valid", resp_valid_o, 0);
      check("flush_capture busy", busy_o, 0);
      flush_i = 1'b0;
      #1;
      check("flush_capture ready", req_ready_o, 1);
      expect_quiet("flush_capture", 6);

`ifdef BMU_CLMUL_EN
      // Flush in the tenth CLMUL_RUN cycle
      issue(5'h10, 32'h3, 32'h3, 5'd11);
      repeat (9) @(negedge clk_i);
      check("flush_clmul busy", busy_o, 1);
      flush_i = 1'b1;
      @(negedge clk_i);
      check("flush_clmul valid", resp_valid_o, 0);
      check("flush_clmul busy_after", busy_o, 0);
      flush_i = 1'b0;
      #1;
      check("flush_clmul ready", req_ready_o, 1);
      expect_quiet("flush_clmul", 40);
`endif
      run_op("after_flush", 5'h03, 32'hCAFE_0000, 32'h0000_BEEF, 5'd12, 0, 32'hCAFE_BEEF, 1'b0, 3);

      // Flush while response is pending without handshake
      issue(5'h1E, 32'h0, 32'h0, 5'd13);
      check("flush_resp valid_before", resp_valid_o, 1);
      flush_i = 1'b1;
      @(negedge clk_i);
      check("flush_resp valid", resp_valid_o, 0);
      flush_i = 1'b0;
      expect_quiet("flush_resp", 4);

      // Flush together with a request must block acceptance
      @(negedge clk_i);
      flush_i = 1'b1; req_valid_i = 1'b1; req_op_i = 5'h04; req_rs1_i = 32'h5; req_rs2_i = 32'h6;
      #1;
      check("flush_req ready", req_ready_o, 0);
      @(negedge clk_i);
      check("flush_req busy", busy_o, 0);
      flush_i = 1'b0; req_valid_i = 1'b0;
      expect_quiet("flush_req", 6);

      // Async reset while in CAPTURE
      issue(5'h05, 32'hDEAD_0000, 32'h0000_BEEF, 5'd14);
      @(negedge clk_i);
      check("rst_cap busy_before", busy_o, 1);
      rst_ni = 1'b0;
      #1;
      check("rst_cap req_ready", req_ready_o, 0);
      check("rst_cap bmu_enable", bmu_enable_o, 0);
      check("rst_cap bmu_op", bmu_op_o, 0);
      check("rst_cap opnd1", bmu_operand1_o, 0);
      check("rst_cap opnd2", bmu_operand2_o, 0);
      check("rst_cap resp_valid", resp_valid_o, 0);
      check("rst_cap result", resp_result_o, 0);
      check("rst_cap rd", resp_rd_o, 0);
      check("rst_cap illegal", resp_illegal_o, 0);
      check("rst_cap busy", busy_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check("rst_cap ready_after", req_ready_o, 1);
      expect_quiet("rst_cap", 6);

      // Random ops against the behavioural model
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 3))
            0, 1:    op = 5'($urandom_range(0, 15));
            2:       op = 5'(16 + $urandom_range(0, 2));
            default: op = 5'($urandom_range(19, 31));
         endcase
         a = $urandom();
         b = $urandom();
         model(op, a, b, r, ill, lat);
         run_op($sformatf("rand%0d", t), op, a, b, 5'($urandom_range(0, 31)),
                int'($urandom_range(0, 3)), r, ill, lat);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
